// File: rtl/uart_line_buffer_ring.sv
// uart_line_buffer_ring: four-line ring of UART pixel lines, streams three complete lines as top/mid/bot taps while the fourth fills
module uart_line_buffer_ring #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int COL_W    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_sync,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  output logic              rd_ready,
  output logic              out_valid,
  output logic [COL_W-1:0]  out_col,
  output logic [DATA_W-1:0] tap_top,
  output logic [DATA_W-1:0] tap_mid,
  output logic [DATA_W-1:0] tap_bot,
  output logic              line_done,
  output logic [2:0]        lines_full,
  output logic              overflow
);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [4][LINE_LEN];
  logic [COL_W-1:0] wr_col, rd_col;
  logic [1:0] wr_line, rd_base, b1, b2;
  logic wr_acc, wr_last, rd_last, rel;
  assign b1 = rd_base + 2'd1;
  assign b2 = rd_base + 2'd2;
  assign wr_acc = wr_en && lines_full != 3'd4 && !frame_sync;
  assign wr_last = wr_acc && wr_col == COL_W'(LINE_LEN - 1);
  assign rd_last = rd_col == COL_W'(LINE_LEN - 1);
  assign rel = state == S_DRAIN;
  // line_done cycle still counts as busy so a new stream cannot start on the release cycle
  assign rd_ready = state == S_IDLE && lines_full >= 3'd3 && !line_done;
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_line][wr_col] <= wr_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_col     <= '0;
      rd_col     <= '0;
      wr_line    <= '0;
      rd_base    <= '0;
      lines_full <= '0;
      overflow   <= 1'b0;
      line_done  <= 1'b0;
      out_valid  <= 1'b0;
      out_col    <= '0;
      tap_top    <= '0;
      tap_mid    <= '0;
      tap_bot    <= '0;
    end else if (frame_sync) begin
      state      <= S_IDLE;
      wr_col     <= '0;
      rd_col     <= '0;
      wr_line    <= '0;
      rd_base    <= '0;
      lines_full <= '0;
      overflow   <= 1'b0;
      line_done  <= 1'b0;
      out_valid  <= 1'b0;
      out_col    <= '0;
      tap_top    <= '0;
      tap_mid    <= '0;
      tap_bot    <= '0;
    end else begin
      if (wr_acc) wr_col <= wr_last ? '0 : wr_col + COL_W'(1);
      if (wr_last) wr_line <= wr_line + 2'd1;
      overflow   <= overflow | (wr_en && lines_full == 3'd4);
      lines_full <= lines_full + 3'(wr_last) - 3'(rel);
      line_done  <= rel;
      out_valid  <= state == S_STREAM;
      out_col    <= rd_col;
      if (state == S_IDLE && rd_start && rd_ready) begin
        state  <= S_STREAM;
        rd_col <= '0;
      end
      if (state == S_STREAM) begin
        tap_top <= mem[rd_base][rd_col];
        tap_mid <= mem[b1][rd_col];
        tap_bot <= mem[b2][rd_col];
        rd_col  <= rd_last ? '0 : rd_col + COL_W'(1);
        if (rd_last) state <= S_DRAIN;
      end
      if (rel) begin
        state   <= S_IDLE;
        rd_base <= rd_base + 2'd1;
      end
    end
  end
endmodule
